// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port frame-buffer RAM between VGA scan-out and the CPU.
// VGA fetches have strict priority; the CPU takes free cycles through a req/ack handshake.
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int WAIT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [WAIT_W-1:0] cpu_wait_cnt
);
    typedef enum logic [1:0] {IDLE, RD, ACK} state_t;
    state_t state, state_nxt;
    logic cpu_gnt, vga_p1;
    logic [ADDR_W-1:0] addr_q;

    assign cpu_gnt   = !vga_req && cpu_req && state == IDLE;
    assign mem_addr  = vga_req ? vga_addr : cpu_gnt ? cpu_addr : addr_q;
    assign mem_we    = reset && cpu_gnt && cpu_we;
    assign mem_wdata = cpu_wdata;

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (cpu_gnt ? (cpu_we ? ACK : RD) : IDLE) :
                    state == RD   ? ACK : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            vga_p1       <= 1'b0;
            vga_valid    <= 1'b0;
            vga_data     <= '0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            cpu_wait_cnt <= '0;
        end else begin
            state     <= state_nxt;
            addr_q    <= mem_addr;
            vga_p1    <= vga_req;
            vga_valid <= vga_p1;
            cpu_ack   <= state_nxt == ACK;
            if (vga_p1)
                vga_data <= mem_rdata;
            if (state == RD)
                cpu_rdata <= mem_rdata;
            // Stall count tracks only cycles the CPU lost to VGA while it could have been served
            if (cpu_gnt)
                cpu_wait_cnt <= '0;
            else if (cpu_req && state == IDLE && vga_req && !(&cpu_wait_cnt))
                cpu_wait_cnt <= cpu_wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized scenario checks of vram_arbiter against a behavioural RAM image.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_valid;
    logic [7:0]  vga_data;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  cpu_wait_cnt;
    logic [7:0]  ram   [0:65535];
    logic [7:0]  model [0:65535];
    int cyc = 0;
    int total = 0;
    int bad = 0;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid), .vga_data(vga_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_wait_cnt(cpu_wait_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous single-port RAM, read-first, 1-cycle latency
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vga_req = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        model[a] = d;
        step();
        step();
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; idle(); vga_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hEE;
        #1;
        total++;
        if ({vga_valid, vga_data, cpu_ack, cpu_rdata, cpu_wait_cnt, mem_we} !== 27'd0) begin
            bad++;
            $display("FAIL reset_init: got %h, expected 0", {vga_valid, vga_data, cpu_ack, cpu_rdata, cpu_wait_cnt, mem_we});
        end
        idle(); reset = 1'b1;
        step();
        cpu_write(16'h0010, 8'h3C);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        step();
        reset = 1'b0; cpu_we = 1'b1; cpu_wdata = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if ({vga_valid, vga_data, cpu_ack, cpu_rdata, cpu_wait_cnt, mem_we} !== 27'd0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %h, expected 0", k, {vga_valid, vga_data, cpu_ack, cpu_rdata, cpu_wait_cnt, mem_we});
            end
            step();
        end
        idle(); reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (cpu_ack !== 1'b0) begin bad++; $display("FAIL reset_no_ack[%0d]: ack=%b expected 0", k, cpu_ack); end
            step();
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        step();
        total++;
        if (cpu_ack !== 1'b0) begin bad++; $display("FAIL reset_read_early: ack=%b expected 0", cpu_ack); end
        step();
        total++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== model[16'h0010]) begin
            bad++;
            $display("FAIL reset_read: ack=%b rdata=%h expected ack=1 rdata=%h", cpu_ack, cpu_rdata, model[16'h0010]);
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
        #1;
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h1234 || mem_wdata !== 8'hA5 || cpu_ack !== 1'b0) begin
            bad++;
            $display("FAIL wr_grant: we=%b addr=%h wdata=%h ack=%b expected 1/1234/a5/0", mem_we, mem_addr, mem_wdata, cpu_ack);
        end
        model[16'h1234] = 8'hA5;
        step();
        total++;
        if (cpu_ack !== 1'b1) begin bad++; $display("FAIL wr_ack: ack=%b expected 1", cpu_ack); end
        step();
        cpu_we = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h1234 || cpu_ack !== 1'b0) begin
            bad++;
            $display("FAIL rd_grant: we=%b addr=%h ack=%b expected 0/1234/0", mem_we, mem_addr, cpu_ack);
        end
        step();
        total++;
        if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_early: ack=%b expected 0", cpu_ack); end
        step();
        total++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== model[16'h1234]) begin
            bad++;
            $display("FAIL rd_ack: ack=%b rdata=%h expected 1/%h", cpu_ack, cpu_rdata, model[16'h1234]);
        end
        cpu_req = 1'b0;
        step();
        total++;
        if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_pulse: ack=%b expected 0", cpu_ack); end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        d = 8'($urandom);
        cpu_write(16'h0001, 8'($urandom));
        vga_req = 1'b1; vga_addr = 16'h0001;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0002; cpu_wdata = d;
        #1;
        total++;
        if (mem_addr !== 16'h0001 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL coll_vga: addr=%h we=%b expected 0001/0", mem_addr, mem_we);
        end
        step();
        vga_req = 1'b0;
        #1;
        total++;
        if (mem_addr !== 16'h0002 || mem_we !== 1'b1 || cpu_wait_cnt !== 8'd1) begin
            bad++;
            $display("FAIL coll_cpu: addr=%h we=%b wait=%0d expected 0002/1/1", mem_addr, mem_we, cpu_wait_cnt);
        end
        model[16'h0002] = d;
        step();
        total++;
        if (cpu_ack !== 1'b1 || cpu_wait_cnt !== 8'd0 || vga_valid !== 1'b1 || vga_data !== model[16'h0001]) begin
            bad++;
            $display("FAIL coll_done: ack=%b wait=%0d vvalid=%b vdata=%h expected 1/0/1/%h",
                     cpu_ack, cpu_wait_cnt, vga_valid, vga_data, model[16'h0001]);
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic test_stream();
        int q_cyc[$];
        logic [7:0] q_dat[$];
        int phase, exp_ack, sent, nvalid, nack, k;
        for (int i = 0; i < 64; i++)
            cpu_write(16'h2000 + 16'(i), 8'($urandom));
        sent = 0; nvalid = 0; nack = 0; phase = 0; exp_ack = 0; k = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2000 + 16'($urandom_range(0, 63));
        while ((phase != 3 || q_cyc.size() > 0) && k < 300) begin
            if (phase == 2) begin
                if (k >= 128) begin cpu_req = 1'b0; phase = 3; end
                else begin cpu_addr = 16'h2000 + 16'($urandom_range(0, 63)); phase = 0; end
            end
            total++;
            if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
                if (vga_valid !== 1'b1 || vga_data !== q_dat[0]) begin
                    bad++;
                    $display("FAIL stream_vga[%0d]: valid=%b data=%h expected 1/%h", nvalid, vga_valid, vga_data, q_dat[0]);
                end
                nvalid++;
                void'(q_cyc.pop_front());
                void'(q_dat.pop_front());
            end else if (vga_valid !== 1'b0) begin
                bad++;
                $display("FAIL stream_vga_spurious: valid=%b at k=%0d expected 0", vga_valid, k);
            end
            total++;
            if (phase == 1 && cyc == exp_ack) begin
                if (cpu_ack !== 1'b1 || cpu_rdata !== model[cpu_addr]) begin
                    bad++;
                    $display("FAIL stream_cpu[%0d]: ack=%b rdata=%h expected 1/%h", nack, cpu_ack, cpu_rdata, model[cpu_addr]);
                end
                nack++;
                phase = 2;
            end else if (cpu_ack !== 1'b0) begin
                bad++;
                $display("FAIL stream_cpu_spurious: ack=%b at k=%0d expected 0", cpu_ack, k);
            end
            vga_req = (k % 2 == 0) && sent < 64;
            if (vga_req) begin
                vga_addr = 16'h2000 + 16'(sent);
                q_cyc.push_back(cyc + 2);
                q_dat.push_back(model[vga_addr]);
                sent++;
            end
            if (phase == 0 && !vga_req) begin
                exp_ack = cyc + 2;
                phase = 1;
            end
            #1;
            total++;
            if (cpu_wait_cnt > 8'd1) begin bad++; $display("FAIL stream_wait: wait=%0d expected <=1", cpu_wait_cnt); end
            step();
            k++;
        end
        idle();
        total++;
        if (k >= 300 || nvalid != 64 || nack < 20) begin
            bad++;
            $display("FAIL stream_count: cycles=%0d valid=%0d acks=%0d expected <300/64/>=20", k, nvalid, nack);
        end
        step();
    endtask

    task automatic test_saturate();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4444; cpu_wdata = 8'h77;
        for (int k = 0; k < 300; k++) begin
            vga_req = 1'b1; vga_addr = 16'($urandom);
            #1;
            total++;
            if (mem_addr !== vga_addr || mem_we !== 1'b0 || cpu_ack !== 1'b0 || cpu_wait_cnt !== 8'(k > 255 ? 255 : k)) begin
                bad++;
                $display("FAIL sat[%0d]: addr=%h we=%b ack=%b wait=%0d expected %h/0/0/%0d",
                         k, mem_addr, mem_we, cpu_ack, cpu_wait_cnt, vga_addr, k > 255 ? 255 : k);
            end
            step();
        end
        vga_req = 1'b0;
        #1;
        total++;
        if (cpu_wait_cnt !== 8'd255 || mem_addr !== 16'h4444 || mem_we !== 1'b1) begin
            bad++;
            $display("FAIL sat_release: wait=%0d addr=%h we=%b expected 255/4444/1", cpu_wait_cnt, mem_addr, mem_we);
        end
        model[16'h4444] = 8'h77;
        step();
        total++;
        if (cpu_ack !== 1'b1 || cpu_wait_cnt !== 8'd0) begin
            bad++;
            $display("FAIL sat_ack: ack=%b wait=%0d expected 1/0", cpu_ack, cpu_wait_cnt);
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] a [4];
        int g, last_g, nack;
        nack = 0; last_g = 0;
        for (int i = 0; i < 4; i++) begin
            a[i] = 16'h5000 + 16'(i * 16) + 16'($urandom_range(0, 15));
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a[i]; cpu_wdata = 8'($urandom);
            #1;
            g = cyc;
            total++;
            if (mem_we !== 1'b1 || mem_addr !== a[i] || mem_wdata !== cpu_wdata || (i > 0 && g - last_g != 2)) begin
                bad++;
                $display("FAIL b2b_grant[%0d]: we=%b addr=%h gap=%0d expected 1/%h/2", i, mem_we, mem_addr, g - last_g, a[i]);
            end
            model[a[i]] = cpu_wdata;
            last_g = g;
            step();
            if (cpu_ack === 1'b1) nack++;
            step();
        end
        cpu_req = 1'b0;
        total++;
        if (nack != 4) begin bad++; $display("FAIL b2b_acks: got %0d expected 4", nack); end
        step();
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a[i];
            step();
            step();
            total++;
            if (cpu_ack !== 1'b1 || cpu_rdata !== model[a[i]]) begin
                bad++;
                $display("FAIL b2b_read[%0d]: ack=%b rdata=%h expected 1/%h", i, cpu_ack, cpu_rdata, model[a[i]]);
            end
            step();
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_stream();
        test_saturate();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Arbitrates the single-port video frame-buffer RAM between two requesters: the VGA scan-out fetch and the game/CPU logic.
- The VGA fetch has strict priority so scan-out never misses a pixel. The CPU gets any cycle the VGA fetch leaves free, through a req/ack handshake.
- Sits inside video_game, between the VGA timing/pixel pipeline, the game logic and the frame-buffer RAM.

Parameters:
- ADDR_W, 16, frame-buffer address width.
- DATA_W, 8, pixel word width.
- WAIT_W, 8, width of the saturating CPU stall counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- vga_req  in  1  VGA fetch request, one cycle per pixel word.
- vga_addr  in  ADDR_W  VGA fetch address, sampled in the request cycle.
- vga_valid  out  1  one-cycle pulse; vga_data is valid.
- vga_data  out  DATA_W  fetched pixel word.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req is high.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack is high after a read.
- mem_addr  out  ADDR_W  RAM address (combinational from the current grant).
- mem_we  out  1  RAM write enable (combinational).
- mem_wdata  out  DATA_W  RAM write data (combinational).
- mem_rdata  in  DATA_W  RAM read data, synchronous, 1-cycle latency.
- cpu_wait_cnt  out  WAIT_W  saturating count of cycles CPU was refused in current request.

Behaviour:
- Reset (reset low, asynchronous):
  - All registered outputs are 0: vga_valid, vga_data, cpu_ack, cpu_rdata, cpu_wait_cnt.
  - CPU FSM goes to IDLE and every in-flight read pipeline bit is cleared.
  - mem_we is forced to 0 combinationally while reset is low. An access in progress is dropped and never acknowledged.
- Grant, decided every cycle:
  - If vga_req, grant VGA.
  - Else if cpu_req and the CPU FSM is IDLE, grant CPU.
  - Otherwise no grant.
- mem_addr:
  - VGA grant: vga_addr.
  - CPU grant: cpu_addr.
  - No grant: holds its last value. Verification does not check it then.
- mem_we is 1 only on a CPU grant with cpu_we = 1. mem_wdata = cpu_wdata.
- VGA path, fully pipelined, may accept a request every cycle:
  - Grant in cycle N gives vga_valid = 1 in N+2, with vga_data = the mem_rdata captured at the end of N+1.
  - Two-stage valid shift register.
- CPU FSM states:
  - IDLE. On a CPU grant with write, go to ACK. On a CPU grant with read, go to RD.
  - RD: mem_rdata is valid in this cycle. Register it into cpu_rdata and go to ACK.
  - ACK: cpu_ack = 1 for exactly this cycle. cpu_req is ignored. Go to IDLE.
- CPU latencies:
  - Write grant in N gives ack in N+1.
  - Read grant in N gives ack in N+2 with cpu_rdata.
  - cpu_rdata holds its value until the next read completes.
- Handshake: the CPU drops cpu_req, or presents a new request, in the cycle after cpu_ack.
  - A new request can be granted in the cycle right after ACK, so back-to-back accesses are one access per 2 cycles (write) or 3 cycles (read).
- cpu_wait_cnt:
  - Increments (saturating at all-ones) in each cycle where cpu_req = 1, the FSM is IDLE and VGA holds the grant.
  - Clears on a CPU grant.
- Collision: vga_req and cpu_req in the same cycle. VGA wins. CPU is stalled with no side effects (mem_we = 0) and is retried automatically the next cycle.
- VGA during CPU RD/ACK: VGA is still granted. RAM port conflicts are impossible because the CPU occupies the port only in its grant cycle.
- Starvation: none under the system contract of at most one vga_req per 2 cycles (clockVGA = clk/2). If the contract is violated, VGA is still served and the CPU waits; cpu_wait_cnt exposes this.

Test Plan:
- Reset mid-read: assert reset low in the RD cycle of a CPU read of address 0x0010.
  - Response: cpu_ack never pulses, all outputs 0 and mem_we 0 while reset is low.
  - After release, a new read of 0x0010 acks in 2 cycles.
- CPU write then read, VGA idle: write 0xA5 to 0x1234.
  - Response: mem_we high in grant cycle N, cpu_ack at N+1.
  - Then read 0x1234: cpu_ack 2 cycles after grant, cpu_rdata = 0xA5.
- Collision: vga_req (addr 0x0001) and a cpu write (addr 0x0002) in the same cycle.
  - Response: mem_addr = 0x0001, mem_we = 0, cpu_wait_cnt = 1.
  - Next cycle: CPU granted, mem_addr = 0x0002, mem_we = 1, cpu_wait_cnt clears.
- VGA streaming: vga_req every other cycle for 64 pixels from a preloaded RAM, interleaved with continuous CPU reads.
  - Response: 64 vga_valid pulses, each exactly 2 cycles after its request, with correct data.
  - Every CPU read acks with correct data, and cpu_wait_cnt never exceeds 1.
- Contract violation: vga_req held high for 300 cycles while cpu_req is high (WAIT_W = 8).
  - Response: cpu_wait_cnt saturates at 255 and no CPU grant occurs.
  - CPU is granted the cycle after vga_req drops.
- Back-to-back CPU writes: 4 writes with cpu_req re-asserted in the cycle after each ack.
  - Response: grants every 2 cycles, 4 ack pulses, and read-back matches.
